// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic TX_IDLE_LVL = 1'b1;
    localparam logic START_LVL   = 1'b0;
    localparam logic STOP_LVL    = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle. The master is the consumer that issues pops;
// the slave is the FIFO that reports empty and presents read data.
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd
    );
endinterface

// File: rtl/fifo_uart_tx_bitclk.sv
// Bit-period timer: counts clk cycles within a serial bit while a frame is
// running and strobes bit_end on the last cycle of each bit period.
// A pop restarts the count so a new frame always begins on a clean period.
module fifo_uart_tx_bitclk #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic bit_end
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt_q;
    logic [CNT_W-1:0] clk_cnt_d;

    // Next count: restart on pop or when idle, wrap at the end of each bit.
    always_comb begin
        clk_cnt_d = clk_cnt_q;
        if (clear || !run) begin
            clk_cnt_d = '0;
        end else if (clk_cnt_q == CNT_MAX) begin
            clk_cnt_d = '0;
        end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
        end
    end

    assign bit_end = run && (clk_cnt_q == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte whenever the FIFO is non-empty and
// enabled, then sends start, DATA_W bits LSB-first, optional parity, stop.
// Optional even-parity bit: define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    fifo_uart_tx_if.master  fifo,
    output logic            tx,
    output logic            busy,
    output logic            frame_done
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pop;
    logic              bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    fifo_uart_tx_bitclk #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bitclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (pop),
        .run     (state_q != IDLE),
        .bit_end (bit_end)
    );

    // Frame sequencing; the registered tx level is chosen for the state being entered.
    always_comb begin
        pop = enable && !fifo.fifo_empty &&
              ((state_q == IDLE) || ((state_q == STOP) && bit_end));
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_MAX) begin
                        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = PARITY;
                        tx_d      = par_q;
`else
                        state_d   = STOP;
                        tx_d      = STOP_LVL;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_d[0];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = STOP_LVL;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = TX_IDLE_LVL;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = TX_IDLE_LVL;
            end
        endcase
        // A pop overrides the idle/stop exit so back-to-back frames have no gap.
        if (pop) begin
            state_d   = START;
            tx_d      = START_LVL;
            shift_d   = fifo.fifo_data;
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_d     = ^fifo.fifo_data;
`endif
        end
        busy_d = (state_d != IDLE);
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE_LVL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Captured byte; only meaningful while a frame is active, so no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign fifo.fifo_rd = pop;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a small FIFO model.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic tx, busy, frame_done;

    fifo_uart_tx_if #(.DATA_W(8)) ifc ();

    // FIFO model: pushes from the stimulus process, pops from the DUT strobe.
    logic [7:0] mem [0:15];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int cyc = 0;
    int last_rd_cyc = -10;
    int bad_rd = 0;
    int errors = 0;
    int checks = 0;

    assign ifc.fifo_empty = (wr_cnt == rd_cnt);
    assign ifc.fifo_data  = mem[rd_cnt[3:0]];

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo       (ifc),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.fifo_rd) rd_cnt <= rd_cnt + 1;
    end

    always @(negedge clk) begin
        if (ifc.fifo_rd) last_rd_cyc = cyc;
        if (ifc.fifo_rd && ifc.fifo_empty) bad_rd = bad_rd + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_cnt[3:0]] = b;
        wr_cnt = wr_cnt + 1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Wait (bounded) for the first tx-low cycle; confirm the pop came the cycle before.
    task automatic wait_tx_low(input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " start_seen"}, (n < 200), 1);
        check({tag, " rd_before_start"}, last_rd_cyc, cyc - 1);
    endtask

    // Called on the first tx-low cycle; returns on the cycle after the last stop cycle.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [CPB-1:0] v;
        int nb, fd;
        logic e;
        nb = 0;
        fd = 0;
        for (int i = 0; i < NBITS; i++) begin
            e = exp_bit(b, i);
            for (int j = 0; j < CPB; j++) begin
                v[j] = tx;
                if (busy) nb++;
                if (frame_done && !(i == 0 && j == 0)) fd++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", tag, i), v, {CPB{e}});
        end
        check({tag, " busy_cycles"}, nb, NBITS * CPB);
        check({tag, " early_done"}, fd, 0);
        check({tag, " done"}, frame_done, 1);
    endtask

    initial begin
        int n_rd, n_low, n_busy, rd0;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", frame_done, 0);
        rst_n = 1'b1;

        // Single 0xA5 frame.
        @(negedge clk);
        push(8'hA5);
        enable = 1'b1;
        wait_tx_low("a5");
        check_frame(8'hA5, "a5");
        check("a5 idle tx", tx, 1);
        check("a5 idle busy", busy, 0);
        @(negedge clk);
        check("a5 done_pulse_width", frame_done, 0);
        check("a5 pops", rd_cnt, 1);

        // Empty FIFO: nothing moves for 100 cycles.
        n_rd = 0; n_low = 0; n_busy = 0;
        for (int k = 0; k < 100; k++) begin
            if (ifc.fifo_rd) n_rd++;
            if (tx !== 1'b1) n_low++;
            if (busy) n_busy++;
            @(negedge clk);
        end
        check("empty rd", n_rd, 0);
        check("empty tx_low", n_low, 0);
        check("empty busy", n_busy, 0);

        // Back-to-back 0x01, 0x80.
        push(8'h01);
        push(8'h80);
        wait_tx_low("b2b1");
        check_frame(8'h01, "b2b1");
        check("b2b gap_tx", tx, 0);
        check("b2b gap_busy", busy, 1);
        check("b2b rd_in_last_stop", last_rd_cyc, cyc - 1);
        check_frame(8'h80, "b2b2");
        check("b2b pops", rd_cnt, 3);

        // Enable dropped in cycle 10 with three bytes queued.
        push(8'h3C);
        push(8'hC3);
        push(8'h5A);
        wait_tx_low("en");
        rd0 = rd_cnt;
        fork
            check_frame(8'h3C, "en");
            begin
                repeat (9) @(negedge clk);
                enable = 1'b0;
            end
        join
        n_rd = 0; n_low = 0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.fifo_rd) n_rd++;
            if (tx !== 1'b1) n_low++;
            @(negedge clk);
        end
        check("en no_rd", n_rd, 0);
        check("en tx_high", n_low, 0);
        check("en left", wr_cnt - rd_cnt, 2);
        check("en pops", rd_cnt, rd0);

        // Reset in cycle 15 of the 0xC3 frame; 0x5A should follow normally.
        enable = 1'b1;
        wait_tx_low("rst");
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst tx", tx, 1);
        check("rst busy", busy, 0);
        check("rst done", frame_done, 0);
        rst_n = 1'b1;
        wait_tx_low("post");
        check_frame(8'h5A, "post");
        check("post all_popped", wr_cnt - rd_cnt, 0);

`ifdef FIFO_UART_TX_PARITY_EN
        @(negedge clk);
        push(8'h07);
        wait_tx_low("par07");
        check_frame(8'h07, "par07");
`endif

        repeat (3) @(negedge clk);
        check("rd_when_empty", bad_rd, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
